// File: rtl/rf_wport_arb.sv
// Write-port arbiter for the register file: two requesters, each with a
// one-entry holding buffer, drained oldest-first with round-robin on ties.
module rf_wport_arb #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   aValid,
  input  logic [SEL_W-1:0]       aSel,
  input  logic [DATA_W-1:0]      aData,
  output logic                   aReady,
  input  logic                   bValid,
  input  logic [SEL_W-1:0]       bSel,
  input  logic [DATA_W-1:0]      bData,
  output logic                   bReady,
  output logic                   writeEn,
  output logic [SEL_W-1:0]       writeRegSel,
  output logic [DATA_W-1:0]      writeData,
  output logic [(1<<SEL_W)-1:0]  pending,
  output logic                   grantB
);

  localparam int NREG = 1 << SEL_W;

  // Handshake: a write transfers at a rising edge when xValid & xReady are
  // both high; xReady is a function of registered state and rst only.

  logic              a_full_q, a_full_d;
  logic [SEL_W-1:0]  a_sel_q, a_sel_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [SEL_W-1:0]  b_sel_q, b_sel_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              rr_q, rr_d;
  logic              older_b_q, older_b_d;
  logic              same_edge_q, same_edge_d;

  logic gnt_a, gnt_b, tie;
  logic acc_a, acc_b;

  // Grant selection purely from buffer state.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    tie   = 1'b0;
    if (a_full_q && b_full_q) begin
      if (same_edge_q) begin
        tie   = 1'b1;
        gnt_b = rr_q;
      end else begin
        gnt_b = older_b_q;
      end
      gnt_a = !gnt_b;
    end else begin
      gnt_a = a_full_q;
      gnt_b = b_full_q;
    end
  end

  assign aReady = !rst && (!a_full_q || gnt_a);
  assign bReady = !rst && (!b_full_q || gnt_b);
  assign acc_a  = aValid && aReady;
  assign acc_b  = bValid && bReady;

  always_comb begin
    a_full_d    = acc_a || (a_full_q && !gnt_a);
    a_sel_d     = acc_a ? aSel  : a_sel_q;
    a_data_d    = acc_a ? aData : a_data_q;
    b_full_d    = acc_b || (b_full_q && !gnt_b);
    b_sel_d     = acc_b ? bSel  : b_sel_q;
    b_data_d    = acc_b ? bData : b_data_q;
    rr_d        = rr_q ^ tie;
    older_b_d   = older_b_q;
    same_edge_d = same_edge_q;
    // A freshly loaded buffer is always younger than one left waiting.
    if (acc_a && acc_b) begin
      same_edge_d = 1'b1;
    end else if (acc_a) begin
      same_edge_d = 1'b0;
      older_b_d   = 1'b1;
    end else if (acc_b) begin
      same_edge_d = 1'b0;
      older_b_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q    <= 1'b0;
      a_sel_q     <= '0;
      a_data_q    <= '0;
      b_full_q    <= 1'b0;
      b_sel_q     <= '0;
      b_data_q    <= '0;
      rr_q        <= 1'b0;
      older_b_q   <= 1'b0;
      same_edge_q <= 1'b0;
    end else begin
      a_full_q    <= a_full_d;
      a_sel_q     <= a_sel_d;
      a_data_q    <= a_data_d;
      b_full_q    <= b_full_d;
      b_sel_q     <= b_sel_d;
      b_data_q    <= b_data_d;
      rr_q        <= rr_d;
      older_b_q   <= older_b_d;
      same_edge_q <= same_edge_d;
    end
  end

  always_comb begin
    writeEn     = !rst && (gnt_a || gnt_b);
    grantB      = !rst && gnt_b;
    writeRegSel = '0;
    writeData   = '0;
    if (!rst && gnt_b) begin
      writeRegSel = b_sel_q;
      writeData   = b_data_q;
    end else if (!rst && gnt_a) begin
      writeRegSel = a_sel_q;
      writeData   = a_data_q;
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) begin
      pending[r] = (a_full_q && (a_sel_q == SEL_W'(r))) ||
                   (b_full_q && (b_sel_q == SEL_W'(r)));
    end
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed scenarios plus random traffic, checked by
// a scoreboard that models arbitration as "oldest pending write wins".
module tb_rf_wport_arb;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
  localparam int NREG   = 1 << SEL_W;
  localparam int ENT_W  = 32 + SEL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aValid = 1'b0, bValid = 1'b0;
  logic [SEL_W-1:0]  aSel = '0, bSel = '0;
  logic [DATA_W-1:0] aData = '0, bData = '0;
  logic              aReady, bReady, writeEn, grantB;
  logic [SEL_W-1:0]  writeRegSel;
  logic [DATA_W-1:0] writeData;
  logic [NREG-1:0]   pending;

  int checks = 0;
  int failures = 0;

  // Each entry: {accept stamp, sel, data}
  logic [ENT_W-1:0]  exp_a_q[$];
  logic [ENT_W-1:0]  exp_b_q[$];
  logic              m_rr = 1'b0;
  logic [31:0]       cyc_n = '0;
  logic [DATA_W-1:0] ref_rf[NREG];
  logic [DATA_W-1:0] dut_rf[NREG];
  logic [DATA_W-1:0] snap_rf[NREG];

  rf_wport_arb #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aSel(aSel), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bSel(bSel), .bData(bData), .bReady(bReady),
    .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .pending(pending), .grantB(grantB)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: present inputs for the coming edge, return 1 time unit after it.
  task automatic step(input logic av, input logic [SEL_W-1:0] as_, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [SEL_W-1:0] bs_, input logic [DATA_W-1:0] bd);
    aValid = av; aSel = as_; aData = ad;
    bValid = bv; bSel = bs_; bData = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, then the model advances past the edge.
  initial begin
    logic [NREG-1:0]  mask;
    logic             have_a, have_b, any, exp_gb, is_tie;
    logic [ENT_W-1:0] ent;
    for (int i = 0; i < NREG; i++) begin
      ref_rf[i] = '0;
      dut_rf[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc_n++;
      mask = '0;
      foreach (exp_a_q[i]) mask[exp_a_q[i][DATA_W +: SEL_W]] = 1'b1;
      foreach (exp_b_q[i]) mask[exp_b_q[i][DATA_W +: SEL_W]] = 1'b1;
      check("pending", 64'(pending), 64'(mask));
      if (rst) begin
        check("rst_ready", 64'({aReady, bReady}), 64'd0);
        check("rst_wen_grant", 64'({writeEn, grantB}), 64'd0);
        check("rst_port", 64'({writeRegSel, writeData}), 64'd0);
        exp_a_q.delete();
        exp_b_q.delete();
        m_rr = 1'b0;
      end else begin
        have_a = (exp_a_q.size() > 0);
        have_b = (exp_b_q.size() > 0);
        any    = have_a || have_b;
        is_tie = 1'b0;
        exp_gb = have_b;
        if (have_a && have_b) begin
          if (exp_a_q[0][ENT_W-1 -: 32] == exp_b_q[0][ENT_W-1 -: 32]) begin
            is_tie = 1'b1;
            exp_gb = m_rr;
          end else begin
            exp_gb = (exp_b_q[0][ENT_W-1 -: 32] < exp_a_q[0][ENT_W-1 -: 32]);
          end
        end
        check("write_en", 64'(writeEn), 64'(any));
        check("a_ready", 64'(aReady), 64'(!have_a || (any && !exp_gb)));
        check("b_ready", 64'(bReady), 64'(!have_b || (any && exp_gb)));
        if (any) begin
          check("grant_b", 64'(grantB), 64'(exp_gb));
          if (exp_gb) ent = exp_b_q.pop_front();
          else        ent = exp_a_q.pop_front();
          check("write_sel", 64'(writeRegSel), 64'(ent[DATA_W +: SEL_W]));
          check("write_data", 64'(writeData), 64'(ent[DATA_W-1:0]));
          ref_rf[ent[DATA_W +: SEL_W]] = ent[DATA_W-1:0];
          if (is_tie) m_rr = !m_rr;
        end else begin
          check("idle_port", 64'({grantB, writeRegSel, writeData}), 64'd0);
        end
        if (writeEn) dut_rf[writeRegSel] = writeData;
        if (aValid && aReady) exp_a_q.push_back({cyc_n, aSel, aData});
        if (bValid && bReady) exp_b_q.push_back({cyc_n, bSel, bData});
      end
    end
  end

  // Stimulus
  initial begin
    logic prev_gb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'({aReady, bReady}), 64'b11);

    // Single write
    step(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0);
    check("single_wen", 64'(writeEn), 64'd1);
    check("single_sel_data", 64'({writeRegSel, writeData}), 64'({3'd3, 16'h1234}));
    check("single_pending", 64'(pending), 64'h08);
    idle();
    check("single_rf", 64'(dut_rf[3]), 64'h1234);
    check("single_pending_clr", 64'(pending), 64'h00);

    // Simultaneous accept, twice: rr alternates the winner
    step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    check("tie1_first_a", 64'({writeEn, grantB, writeRegSel}), 64'({1'b1, 1'b0, 3'd1}));
    check("tie1_b_blocked", 64'(bReady), 64'd0);
    idle();
    check("tie1_second_b", 64'({grantB, writeRegSel, writeData}), 64'({1'b1, 3'd2, 16'h5555}));
    idle();
    step(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    check("tie2_first_b", 64'({writeEn, grantB, writeRegSel}), 64'({1'b1, 1'b1, 3'd2}));
    idle();
    check("tie2_second_a", 64'({grantB, writeRegSel, writeData}), 64'({1'b0, 3'd1, 16'hAAAA}));
    idle();

    // Same-register ordering: A(r5) waits behind an older B write
    step(1'b1, 3'd0, 16'h00F0, 1'b1, 3'd6, 16'h0003);
    check("ord_tie_a", 64'(grantB), 64'd0);
    step(1'b1, 3'd5, 16'h0001, 1'b0, '0, '0);
    check("ord_b_older", 64'({grantB, writeRegSel, aReady}), 64'({1'b1, 3'd6, 1'b0}));
    check("ord_pend5_a", 64'(pending[5]), 64'd1);
    step(1'b0, '0, '0, 1'b1, 3'd5, 16'h0002);
    check("ord_a_first", 64'({grantB, writeRegSel, writeData}), 64'({1'b0, 3'd5, 16'h0001}));
    idle();
    check("ord_b_last", 64'({grantB, writeRegSel, writeData}), 64'({1'b1, 3'd5, 16'h0002}));
    check("ord_pend5_b", 64'(pending[5]), 64'd1);
    idle();
    check("ord_pend5_clr", 64'(pending[5]), 64'd0);
    check("ord_r5_final", 64'(dut_rf[5]), 64'h0002);

    // Streaming: A on even registers, B on odd, both valid every cycle
    prev_gb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, SEL_W'(2 * $urandom_range(0, 3)), DATA_W'($urandom),
           1'b1, SEL_W'(2 * $urandom_range(0, 3) + 1), DATA_W'($urandom));
      if (i > 0) begin
        check("stream_wen", 64'(writeEn), 64'd1);
        check("stream_alt", 64'(grantB), 64'(!prev_gb));
      end
      prev_gb = grantB;
    end
    repeat (3) idle();

    // Reset mid-operation with both buffers full
    step(1'b1, 3'd3, DATA_W'($urandom), 1'b1, 3'd4, DATA_W'($urandom));
    for (int i = 0; i < NREG; i++) snap_rf[i] = dut_rf[i];
    rst = 1'b1;
    idle();
    check("rstmid_pending", 64'(pending), 64'd0);
    check("rstmid_wen", 64'(writeEn), 64'd0);
    rst = 1'b0;
    #1;
    check("rstmid_ready", 64'({aReady, bReady}), 64'b11);
    idle();
    check("rstmid_no_write", 64'(writeEn), 64'd0);
    for (int i = 0; i < NREG; i++) check("rstmid_rf", 64'(dut_rf[i]), 64'(snap_rf[i]));

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), SEL_W'($urandom), DATA_W'($urandom),
           1'($urandom_range(0, 1)), SEL_W'($urandom), DATA_W'($urandom));
    end
    repeat (4) idle();
    check("drain_a_empty", 64'(exp_a_q.size()), 64'd0);
    check("drain_b_empty", 64'(exp_b_q.size()), 64'd0);
    check("drain_pending", 64'(pending), 64'd0);
    for (int i = 0; i < NREG; i++) check("final_rf", 64'(dut_rf[i]), 64'(ref_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wport_arb.md
# rf_wport_arb

Write-port arbiter for the 8x16b register file (`regFile_hier`). It shares the file's single write port between two independent writeback requesters, A and B, each behind a valid/ready handshake with a one-entry holding buffer. Buffered writes drain in age order, with round-robin tie-breaking. A pending-write mask lets read-side logic detect registers with queued writes. The block sits between the writeback sources and the `writeRegSel`/`writeData`/`writeEn` inputs of the register file.

## Interface
- `DATA_W`, default 16: write data width.
- `SEL_W`, default 3: register select width; the file has 2^SEL_W registers.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `aValid`  in  1: requester A offers a write.
- `aSel`  in  SEL_W: A target register.
- `aData`  in  DATA_W: A write data.
- `aReady`  out  1: A buffer can accept this cycle.
- `bValid`, `bSel`, `bData`, `bReady`: same as A, for requester B.
- `writeEn`  out  1: to register file.
- `writeRegSel`  out  SEL_W: to register file.
- `writeData`  out  DATA_W: to register file.
- `pending`  out  2^SEL_W: bit r = 1 while any buffer holds a write to register r.
- `grantB`  out  1: current write comes from B (0 = A or idle); for debug and bench use.

## Operation
- State: two buffers (`full`, `sel`, `data`, `seq`), a 1-bit round-robin pointer `rr` (0 = A preferred), and a 1-bit age flag recording which buffer was loaded first.
- Accept: a transfer happens at a rising edge when `xValid & xReady`. The buffer loads `sel`/`data` and sets `full`.
- Readiness: `xReady = !rst & (!xFull | xGranted)`. It depends only on state, never on `xValid`, so no combinational path runs from valid to ready.
- Grant (combinational from state):
  - Neither buffer full: no grant, `writeEn = 0`.
  - One buffer full: grant that buffer.
  - Both full, different load edges: grant the older buffer.
  - Both full, loaded on the same edge: grant the side selected by `rr`, then toggle `rr` at that edge.
- Write port: `writeEn = !rst & anyGrant`. `writeRegSel`/`writeData` come from the granted buffer. When idle they are held at 0.
- Drain: the granted buffer clears `full` at the next edge, unless the same side is accepted at that edge, in which case it reloads. A reloaded buffer is younger than any buffer still waiting.
- Same-register collisions resolve in age order, so the later-accepted value lands last. For same-edge acceptance, order follows `rr`; requesters must not depend on it.
- `pending[r] = (aFull & aSel==r) | (bFull & bSel==r)`.

## Timing
- Latency: accepted at edge N. If granted in cycle N..N+1, the register file captures it at edge N+1. If it loses arbitration, the register file captures it at edge N+2.
- Throughput: one write per cycle sustained. With both requesters streaming, grants alternate A/B.
- Worst-case wait: one cycle behind the other buffer.
- Reset (rst high at an edge): both buffers are emptied, `rr = 0`, and the age flag clears. Held writes are dropped, never written.
- While `rst` is high:
  - `aReady`, `bReady`, `writeEn`, `grantB` are 0.
  - `pending` reads 0 from the edge after reset is first sampled.
  - `writeRegSel`/`writeData` are 0.
- Reset mid-operation behaves identically: a buffered write is lost even if it was granted in that cycle.
- After `rst` falls, `aReady = bReady = 1` in the first cycle.
- All outputs except registered state are combinational from state. The only combinational input dependence is none: the outputs depend solely on registered state and `rst`.

## Test plan
- **Single write:** A writes sel=3, data=0x1234 one cycle after reset release.
  - Response: `writeEn = 1`, `writeRegSel = 3`, `writeData = 0x1234` in the next cycle, with `pending = 0x08`.
  - Follow-up: a read of r3 returns 0x1234 after the following edge, and `pending = 0x00`.
- **Simultaneous accept:** A (r1, 0xAAAA) and B (r2, 0x5555) are accepted on the same edge.
  - Response: A writes first (rr = 0), then B on the next cycle; `bReady = 0` for one cycle.
  - Repeat: the next tie goes to B first.
- **Same-register ordering:** A is accepted (r5, 0x0001), and B (r5, 0x0002) is accepted one cycle later while A is blocked by an earlier B write.
  - Response: final r5 = 0x0002; `pending[5]` stays set until the last write.
- **Streaming:** A and B hold `valid = 1` for 20 cycles with distinct registers.
  - Response: exactly one write per cycle after the first, grants strictly alternate, no data lost or duplicated (checked against a reference register-file model).
- **Reset mid-operation:** both buffers are full when `rst` pulses for 1 cycle.
  - Response: no `writeEn` during or after the pulse for the dropped entries, `pending = 0`, and the register file contents are unchanged.
- **Random:** 500 cycles of random valid/sel/data on both sides.
  - Response: reads match a reference model updated in grant order, `writeEn` never asserts without a full buffer, and `xReady` never depends on `xValid`.
